// File: rtl/add8_rr_sched_pkg.sv
// Shared defaults, id-width helper and FSM state type for the add8_rr_sched
// round-robin shared adder.
package add8_rr_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int id_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add8_rr_sched_core.sv
// Combinational W-bit adder shared by all requesters of add8_rr_sched;
// exposes the carry so the top can optionally register it.
module add8_core
  import add8_rr_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add8_rr_sched.sv
// Round-robin scheduler feeding NREQ requesters into one registered adder slot.
// Define ADD8_RR_SCHED_COUT_EN to add the registered carry output res_cout.
module add8_rr_sched
  import add8_rr_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int W    = W_DEF,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic [ID_W-1:0]   res_id,
  output logic              busy
`ifdef ADD8_RR_SCHED_COUT_EN
  ,
  output logic              res_cout
`endif
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0]      res_sum_q, res_sum_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_cout_q, res_cout_d;

  logic              slot_free;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic              accept;
  logic [W-1:0]      a_sel, b_sel;
  logic [W-1:0]      core_sum;
  logic              core_cout;

  assign slot_free = (state_q == ST_EMPTY) || res_ready;

  // Search from rr_ptr upward, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign accept = slot_free && grant_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        a_sel = req_a[k*W +: W];
        b_sel = req_b[k*W +: W];
      end
    end
  end

  add8_core #(.W(W)) u_core (
    .a    (a_sel),
    .b    (b_sel),
    .sum  (core_sum),
    .cout (core_cout)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    res_sum_d  = res_sum_q;
    res_id_d   = res_id_q;
    res_cout_d = res_cout_q;
    if (accept) begin
      state_d    = ST_FULL;
      res_sum_d  = core_sum;
      res_id_d   = grant_id;
      res_cout_d = core_cout;
      rr_ptr_d   = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
    end else if (state_q == ST_FULL && res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      res_sum_q  <= '0;
      res_id_q   <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      res_sum_q  <= res_sum_d;
      res_id_q   <= res_id_d;
      res_cout_q <= res_cout_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign busy      = res_valid || (|req_valid);

`ifdef ADD8_RR_SCHED_COUT_EN
  assign res_cout = res_cout_q;
`else
  // Carry is computed but intentionally dropped in the default build.
  logic unused_cout;
  assign unused_cout = core_cout ^ res_cout_q;
`endif

endmodule
